// File: rtl/psum_pkg.sv
// Shared defaults, state encoding and accumulator limits for psum_accumulator.
package psum_pkg;

  localparam int LANES = 16;
  localparam int IN_W  = 16;
  localparam int ACC_W = 24;
  localparam int K_W   = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    EMIT  = 2'd2
  } state_t;

  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

endpackage

// File: rtl/psum_lane.sv
// One accumulator lane: sign-extends the input and adds it to the lane register.
// Define PSUM_SAT_EN to clamp on overflow instead of wrapping.
module psum_lane #(
  parameter int IN_W  = 16,
  parameter int ACC_W = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             en,
  input  logic [IN_W-1:0]  din,
  output logic [ACC_W-1:0] acc
);
  import psum_pkg::*;

  logic [ACC_W-1:0] nxt;

`ifdef PSUM_SAT_EN
  localparam logic [ACC_W-1:0] LANE_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] LANE_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  // One guard bit: the top two bits disagree exactly when the add overflowed.
  logic [ACC_W:0] sum;
  assign sum = {acc[ACC_W-1], acc} + {{(ACC_W+1-IN_W){din[IN_W-1]}}, din};

  always_comb begin
    nxt = sum[ACC_W-1:0];
    if (sum[ACC_W] != sum[ACC_W-1]) nxt = sum[ACC_W] ? LANE_MIN : LANE_MAX;
  end
`else
  assign nxt = acc + {{(ACC_W-IN_W){din[IN_W-1]}}, din};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     acc <= '0;
    else if (clear) acc <= '0;
    else if (en)    acc <= nxt;
  end

endmodule

// File: rtl/psum_accumulator.sv
// Job sequencer around LANES psum_lane instances; presents the partial-sum vector to ppu.
// Optional feature: define PSUM_SAT_EN for saturating lanes (default wraps).
module psum_accumulator #(
  parameter int LANES = psum_pkg::LANES,
  parameter int IN_W  = psum_pkg::IN_W,
  parameter int ACC_W = psum_pkg::ACC_W,
  parameter int K_W   = psum_pkg::K_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [K_W-1:0]         k_len,
  input  logic [7:0]             scale_in,
  input  logic [7:0]             bias_in,
  input  logic                   in_valid,
  input  logic [LANES*IN_W-1:0]  in_data,
  output logic                   in_ready,
  output logic [LANES*ACC_W-1:0] partial_sum,
  output logic [7:0]             scale,
  output logic [7:0]             bias,
  output logic                   valid,
  input  logic                   out_ready,
  output logic                   busy
);
  import psum_pkg::*;

  state_t         state;
  logic [K_W-1:0] k_reg;
  logic [K_W-1:0] cnt;
  logic [K_W-1:0] cnt_nxt;
  logic           lane_clear;
  logic           lane_en;

  // Handshakes: a beat transfers on the edge where in_valid && in_ready, a result
  // on the edge where valid && out_ready; both ready/valid are registered state flags.
  assign cnt_nxt    = cnt + K_W'(1);
  assign lane_clear = (state == IDLE) && start;
  assign lane_en    = in_ready && in_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      k_reg    <= '0;
      cnt      <= '0;
      scale    <= '0;
      bias     <= '0;
      in_ready <= 1'b0;
      valid    <= 1'b0;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            k_reg <= k_len;
            scale <= scale_in;
            bias  <= bias_in;
            cnt   <= '0;
            busy  <= 1'b1;
            if (k_len == '0) begin
              state <= EMIT;
              valid <= 1'b1;
            end else begin
              state    <= ACCUM;
              in_ready <= 1'b1;
            end
          end
        end
        ACCUM: begin
          if (lane_en) begin
            cnt <= cnt_nxt;
            if (cnt_nxt == k_reg) begin
              state    <= EMIT;
              in_ready <= 1'b0;
              valid    <= 1'b1;
            end
          end
        end
        EMIT: begin
          if (out_ready) begin
            state <= IDLE;
            valid <= 1'b0;
            busy  <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b0;
          valid    <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    psum_lane #(
      .IN_W  (IN_W),
      .ACC_W (ACC_W)
    ) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (lane_clear),
      .en    (lane_en),
      .din   (in_data[i*IN_W +: IN_W]),
      .acc   (partial_sum[i*ACC_W +: ACC_W])
    );
  end

endmodule

// File: tb/tb_psum_accumulator.sv
// Directed-plus-random bench for psum_accumulator with an arithmetic reference model.
module tb_psum_accumulator;
  import psum_pkg::*;

  localparam int PW = LANES * ACC_W;
  localparam int DW = LANES * IN_W;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [K_W-1:0] k_len;
  logic [7:0]    scale_in, bias_in, scale, bias;
  logic          in_valid, in_ready, valid, out_ready, busy;
  logic [DW-1:0] in_data;
  logic [PW-1:0] partial_sum;

  int total = 0;
  int bad   = 0;
  logic [PW-1:0] exp_q[$];
  longint m[LANES];

  psum_accumulator dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .k_len       (k_len),
    .scale_in    (scale_in),
    .bias_in     (bias_in),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .partial_sum (partial_sum),
    .scale       (scale),
    .bias        (bias),
    .valid       (valid),
    .out_ready   (out_ready),
    .busy        (busy)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: integer sum per lane, then either clamp or reduce modulo 2^24.
  function automatic longint step(input longint a, input longint x);
    longint s;
    s = a + x;
`ifdef PSUM_SAT_EN
    if (s > 64'sd8388607) s = 64'sd8388607;
    else if (s < -64'sd8388608) s = -64'sd8388608;
`else
    s = s & 64'sh0FFFFFF;
    if (s >= 64'sd8388608) s = s - 64'sd16777216;
`endif
    return s;
  endfunction

  function automatic logic [PW-1:0] model_vec();
    logic [PW-1:0] v;
    for (int i = 0; i < LANES; i++) v[i*ACC_W +: ACC_W] = ACC_W'(m[i]);
    return v;
  endfunction

  function automatic logic [PW-1:0] splat(input logic [ACC_W-1:0] x);
    logic [PW-1:0] v;
    for (int i = 0; i < LANES; i++) v[i*ACC_W +: ACC_W] = x;
    return v;
  endfunction

  function automatic logic [DW-1:0] gen(input int mode, input logic [IN_W-1:0] cval);
    logic [DW-1:0] d;
    for (int i = 0; i < LANES; i++) begin
      if (mode == 0)      d[i*IN_W +: IN_W] = cval;
      else if (mode == 1) d[i*IN_W +: IN_W] = IN_W'(i);
      else                d[i*IN_W +: IN_W] = IN_W'($urandom);
    end
    return d;
  endfunction

  // ---------------- driver ----------------
  task automatic run_job(input string tag, input int k, input int mode, input logic [IN_W-1:0] cval,
                         input int gap_lo, input int gap_hi, input int stall,
                         output logic [PW-1:0] ps);
    logic [7:0]    sc, bi;
    logic [DW-1:0] d;
    logic [PW-1:0] expv, held;
    sc = 8'($urandom);
    bi = 8'($urandom);
    for (int i = 0; i < LANES; i++) m[i] = 0;
    start = 1'b1; k_len = K_W'(k); scale_in = sc; bias_in = bi;
    tick();
    start = 1'b0; scale_in = 8'($urandom); bias_in = 8'($urandom);
    chk({tag, "_busy"}, PW'(busy), PW'(1));
    chk({tag, "_in_ready_start"}, PW'(in_ready), PW'(k != 0));
    for (int b = 0; b < k; b++) begin
      int gap;
      gap = $urandom_range(gap_hi, gap_lo);
      for (int g = 0; g < gap; g++) begin
        in_valid = 1'b0;
        in_data  = gen(2, '0);
        tick();
        chk({tag, "_in_ready_gap"}, PW'(in_ready), PW'(1));
      end
      d = gen(mode, cval);
      in_valid = 1'b1;
      in_data  = d;
      for (int i = 0; i < LANES; i++) m[i] = step(m[i], longint'($signed(d[i*IN_W +: IN_W])));
      tick();
      in_valid = 1'b0;
      if (b < k - 1) chk({tag, "_valid_early"}, PW'(valid), PW'(0));
    end
    exp_q.push_back(model_vec());
    chk({tag, "_valid"}, PW'(valid), PW'(1));
    chk({tag, "_in_ready_emit"}, PW'(in_ready), PW'(0));
    chk({tag, "_scale"}, PW'(scale), PW'(sc));
    chk({tag, "_bias"}, PW'(bias), PW'(bi));
    expv = exp_q.pop_front();
    chk({tag, "_psum"}, partial_sum, expv);
    held = partial_sum;
    ps = partial_sum;
    out_ready = 1'b0;
    for (int s = 0; s < stall; s++) begin
      start    = 1'b1;
      k_len    = K_W'($urandom);
      in_valid = 1'b1;
      in_data  = gen(2, '0);
      tick();
      chk({tag, "_hold_valid"}, PW'(valid), PW'(1));
      chk({tag, "_hold_psum"}, partial_sum, held);
      chk({tag, "_hold_in_ready"}, PW'(in_ready), PW'(0));
      chk({tag, "_hold_scale"}, PW'(scale), PW'(sc));
    end
    // start during the handshake cycle must not launch a job
    start = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    start = 1'b0; in_valid = 1'b0;
    chk({tag, "_done_valid"}, PW'(valid), PW'(0));
    chk({tag, "_done_busy"}, PW'(busy), PW'(0));
    chk({tag, "_done_in_ready"}, PW'(in_ready), PW'(0));
    tick();
    chk({tag, "_idle_busy"}, PW'(busy), PW'(0));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [PW-1:0] ps, expv;
    rst_n = 1'b0; start = 1'b0; k_len = '0; scale_in = '0; bias_in = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    #1;
    chk("rst_psum", partial_sum, '0);
    chk("rst_valid", PW'(valid), PW'(0));
    chk("rst_in_ready", PW'(in_ready), PW'(0));
    chk("rst_busy", PW'(busy), PW'(0));
    chk("rst_scale", PW'(scale), PW'(0));
    chk("rst_bias", PW'(bias), PW'(0));
    tick(); tick();
    rst_n = 1'b1;
    tick();

    run_job("basic", 4, 0, 16'h0100, 0, 0, 0, ps);
    chk("basic_const", ps, splat(24'h000400));

    run_job("gaps", 3, 1, '0, 2, 2, 0, ps);
    for (int i = 0; i < LANES; i++) expv[i*ACC_W +: ACC_W] = ACC_W'(3 * i);
    chk("gaps_const", ps, expv);

    run_job("ovf_pos", 300, 0, 16'h7FFF, 0, 0, 0, ps);
`ifdef PSUM_SAT_EN
    chk("ovf_pos_const", ps, splat(24'h7FFFFF));
`else
    chk("ovf_pos_const", ps, splat(24'h95FED4));
`endif

    run_job("ovf_neg", 300, 0, 16'h8000, 0, 0, 0, ps);
`ifdef PSUM_SAT_EN
    chk("ovf_neg_const", ps, splat(24'h800000));
`else
    chk("ovf_neg_const", ps, splat(24'h6A0000));
`endif

    run_job("bp", 2, 2, '0, 0, 1, 3, ps);
    run_job("zero", 0, 0, '0, 0, 0, 0, ps);
    chk("zero_const", ps, '0);

    for (int j = 0; j < 5; j++) begin
      run_job("rand", $urandom_range(8, 1), 2, '0, 0, 2, $urandom_range(3, 0), ps);
    end

    // reset in the middle of a five-beat job
    start = 1'b1; k_len = K_W'(5); scale_in = 8'h5A; bias_in = 8'hA5;
    tick();
    start = 1'b0;
    for (int b = 0; b < 2; b++) begin
      in_valid = 1'b1; in_data = gen(0, 16'h0100);
      tick();
    end
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_psum", partial_sum, '0);
    chk("mrst_valid", PW'(valid), PW'(0));
    chk("mrst_in_ready", PW'(in_ready), PW'(0));
    chk("mrst_busy", PW'(busy), PW'(0));
    chk("mrst_scale", PW'(scale), PW'(0));
    chk("mrst_bias", PW'(bias), PW'(0));
    tick();
    rst_n = 1'b1;
    tick();
    run_job("after_rst", 1, 0, 16'h0003, 0, 0, 0, ps);
    chk("after_rst_const", ps, splat(24'h000003));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/psum_accumulator.md
# psum_accumulator

Upstream producer for the post-processing unit (`ppu`). It accumulates a stream of per-lane signed products over a programmable reduction depth. When the job completes, it presents the 16 × 24-bit partial-sum vector, plus the job's scale and bias, on the `partial_sum`/`scale`/`bias`/`valid` interface that `ppu` consumes. It sits between the MAC array output and `ppu`, and owns job sequencing and output backpressure.

## Interface
- `LANES`, default 16: number of accumulator lanes.
- `IN_W`, default 16: signed input width per lane.
- `ACC_W`, default 24: signed accumulator width per lane.
- `K_W`, default 10: width of the reduction-depth field.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: launch a job; sampled only in IDLE.
- `k_len`  in  K_W: number of input beats in the job; latched on `start`.
- `scale_in`  in  8: job scale; latched on `start`.
- `bias_in`  in  8: job bias; latched on `start`.
- `in_valid`  in  1: input beat valid.
- `in_data`  in  LANES*IN_W: lane i occupies `[i*IN_W +: IN_W]`, two's complement.
- `in_ready`  out  1: accepting input beats.
- `partial_sum`  out  LANES*ACC_W: lane i occupies `[i*ACC_W +: ACC_W]`.
- `scale`  out  8: latched job scale.
- `bias`  out  8: latched job bias.
- `valid`  out  1: `partial_sum`/`scale`/`bias` valid.
- `out_ready`  in  1: consumer accepts; tie to 1 when driving `ppu` directly.
- `busy`  out  1: high in ACCUM or EMIT.

## Operation
- States:
  - IDLE: `in_ready`=0, `valid`=0.
  - ACCUM: `in_ready`=1.
  - EMIT: `valid`=1, `in_ready`=0.
- IDLE→ACCUM on `start`:
  - clear all accumulators and the beat counter;
  - latch `k_len`, `scale_in`, `bias_in`.
- If `k_len`=0, go IDLE→EMIT directly and emit all-zero `partial_sum`.
- In ACCUM, each beat with `in_valid && in_ready`:
  - each lane adds its sign-extended `in_data` lane to its accumulator;
  - the beat counter increments.
- ACCUM→EMIT on the beat that makes the counter equal the latched `k_len`.
- EMIT→IDLE on `valid && out_ready`.
- `start` is ignored outside IDLE, including in the EMIT handshake cycle.
- Overflow handling follows `PSUM_SAT_EN` (see Configuration).
- `scale` and `bias` hold their latched values from `start` until the next `start`.

## Timing
- Reset values:
  - `in_ready`=0, `valid`=0, `busy`=0;
  - `partial_sum`=0, `scale`=0, `bias`=0;
  - state IDLE, counter 0.
- `start` at edge t puts the block in ACCUM from t+1, so `in_ready`=1 from cycle t+1.
- Last beat accepted at edge t: `valid`=1 and final `partial_sum` registered at t+1. Latency from last beat to `valid` is 1 cycle.
- `k_len`=0: `valid`=1 one cycle after `start`.
- While `valid`=1 and `out_ready`=0, all outputs are held stable.
- `valid` drops the cycle after the handshake. The earliest new `start` is accepted in the following IDLE cycle, so back-to-back job throughput is k_len+2 cycles.
- `in_valid` while not in ACCUM has no effect.
- Asserting `rst_n` low at any point forces all outputs to their reset values immediately, with no residue in the next job.

## Configuration
- `PSUM_SAT_EN` defined: each lane saturates on add, clamping to 0x7FFFFF (positive overflow) or 0x800000 (negative overflow).
- `PSUM_SAT_EN` undefined: plain two's-complement wrap at ACC_W bits.

## Structure
- Package `psum_pkg` holds:
  - `LANES`, `IN_W`, `ACC_W`, `K_W` defaults;
  - the state enum (IDLE, ACCUM, EMIT);
  - `ACC_MAX` and `ACC_MIN` constants.
- Sub-module `psum_lane`: one lane's register, sign-extension and saturating/wrapping add, instantiated LANES times.
- FSM, counter and handshake live in the top module.

## Test plan
- Basic job: `start`, `k_len`=4, every lane 0x0100 for 4 beats, `out_ready`=1 → `valid` one cycle after 4th beat; every lane 0x000400; `scale` and `bias` equal the values given at `start`.
- Input stalls: `k_len`=3 with `in_valid` gaps of 2 cycles between beats, lane i = i → lane i = 3*i; `in_ready` remains 1 through the gaps.
- Overflow: `k_len`=300, all lanes 0x7FFF →
  - with `PSUM_SAT_EN`: 0x7FFFFF;
  - without it: 0x95FED4.
  - Same test with all lanes 0x8000 and `PSUM_SAT_EN` → 0x800000.
- Backpressure: hold `out_ready`=0 for 3 cycles in EMIT while pulsing `start` and `in_valid` → `valid` and `partial_sum` stable; `in_ready`=0; `start` ignored; IDLE after `out_ready`=1.
- Zero-length job: `k_len`=0 → `valid` one cycle after `start`, `partial_sum`=0.
- Reset mid-job: drive `rst_n` low after 2 of 5 beats → outputs are zero immediately. Next job with `k_len`=1 and lanes 0x0003 → lanes 0x000003.
